// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Controller state encoding and the largest supported operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/add_sub_ext.sv
// (WIDTH+1)-bit adder/subtractor with optional sign extension of both operands.
// Combinational, zero latency; no flow control.
module add_sub_ext #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign_ext,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    assign a_ext = {sign_ext & a[WIDTH-1], a};
    assign b_ext = {sign_ext & b[WIDTH-1], b};
    assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or two's-complement.
// Latency: Done pulses WIDTH edges after the Start edge; Start is ignored while Busy (no queueing).
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic [2*WIDTH-1:0] Data_Out,
    output logic               X,
    output logic               Busy,
    output logic               Done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic             last;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sum;

    assign last = (cnt_q == LAST_CNT);

    // Signed mode subtracts on the final step: the multiplier's top bit carries negative weight.
    add_sub_ext #(
        .WIDTH(WIDTH)
    ) u_add_sub (
        .a       (a_q),
        .b       (s_q),
        .sub     (mode_q & last),
        .sign_ext(mode_q),
        .sum     (add_sum)
    );

    assign sum = b_q[0] ? add_sum : {x_q, a_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        if (Abort) begin
            state_d = IDLE;
            a_d     = '0;
            x_d     = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        s_d     = A_in;
                        b_d     = B_in;
                        mode_d  = Signed_Mode;
                        a_d     = '0;
                        x_d     = 1'b0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Arithmetic right shift of {sum, B}; unsigned mode parks the carry in A's MSB.
                    x_d   = mode_q ? sum[WIDTH] : 1'b0;
                    a_d   = {sum[WIDTH], sum[WIDTH-1:1]};
                    b_d   = {sum[0], b_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign Data_Out = {a_q, b_q};
    assign X        = x_q;
    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult at WIDTH 8, 16 and 2 with hand-computed products.
module tb_shift_add_mult;

    logic clk;
    logic rst;

    logic        start8, abort8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] do8;
    logic        x8, busy8, done8;

    logic        start16, abort16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] do16;
    logic        x16, busy16, done16;

    logic        start2, abort2, sm2;
    logic [1:0]  a2, b2;
    logic [3:0]  do2;
    logic        x2, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    shift_add_mult #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .Abort(abort8), .Signed_Mode(sm8),
        .A_in(a8), .B_in(b8), .Data_Out(do8), .X(x8), .Busy(busy8), .Done(done8)
    );

    shift_add_mult #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .Start(start16), .Abort(abort16), .Signed_Mode(sm16),
        .A_in(a16), .B_in(b16), .Data_Out(do16), .X(x16), .Busy(busy16), .Done(done16)
    );

    shift_add_mult #(.WIDTH(2)) dut2 (
        .Clk(clk), .Reset(rst), .Start(start2), .Abort(abort2), .Signed_Mode(sm2),
        .A_in(a2), .B_in(b2), .Data_Out(do2), .X(x2), .Busy(busy2), .Done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full WIDTH=8 multiply; operands are scrambled right after the Start edge.
    task automatic mul8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input logic exp_x);
        int cyc;
        int busy_n;
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
        cyc = 0;
        busy_n = busy8 ? 1 : 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) busy_n++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd8);
        chk({tag, "_product"}, 64'(do8), 64'(exp));
        chk({tag, "_x"}, 64'(x8), 64'(exp_x));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd9);
        @(negedge clk);
        chk({tag, "_idle_after"}, {62'd0, busy8, done8}, 64'd0);
        chk({tag, "_hold"}, 64'(do8), 64'(exp));
    endtask

    initial begin
        int cyc;
        int n_done;
        int done_at;
        logic [15:0] dat_at_done;

        rst = 1'b1;
        start8 = 0; abort8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; abort16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        start2 = 0; abort2 = 0; sm2 = 0; a2 = 0; b2 = 0;

        #12;
        chk("reset_state", {46'd0, do8, x8, busy8, done8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        mul8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        mul8("s_m3_7",  1'b1, 8'hFD, 8'h07, 16'hFFEB, 1'b1);
        mul8("s_80_7f", 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1);
        mul8("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);

        // Start re-pulsed during RUN must be ignored.
        @(negedge clk);
        sm8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_done = 0; done_at = -1; dat_at_done = '0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin start8 = 1'b1; b8 = 8'h00; end
            if (i == 4) start8 = 1'b0;
            @(negedge clk);
            if (done8) begin
                n_done++;
                done_at = i;
                dat_at_done = do8;
            end
        end
        chk("restart_done_count", 64'(n_done), 64'd1);
        chk("restart_done_at", 64'(done_at), 64'd8);
        chk("restart_product", 64'(dat_at_done), 64'h0001);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        chk("pre_reset_busy", 64'(busy8), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {46'd0, do8, busy8, done8, x8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_stays_idle", 64'(busy8), 64'd0);
        mul8("u_3_5", 1'b0, 8'h03, 8'h05, 16'h000F, 1'b0);

        // Abort mid-run.
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'hAB; b8 = 8'hCD; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 4; i++) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        chk("abort_idle", {61'd0, busy8, done8, x8}, 64'd0);
        chk("abort_a_clear", 64'(do8[15:8]), 64'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);

        // Abort wins over Start in IDLE.
        abort8 = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        chk("abort_start_idle", 64'(busy8), 64'd0);
        abort8 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("abort_start_still_idle", {62'd0, busy8, done8}, 64'd0);
        mul8("u_after_abort", 1'b0, 8'h0C, 8'h0B, 16'h0084, 1'b0);

        // WIDTH=16 signed.
        @(negedge clk);
        sm16 = 1'b1; a16 = 16'h8000; b16 = 16'hFFFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'h1234; b16 = 16'h0000;
        cyc = 0;
        while (done16 !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("w16_latency", 64'(cyc), 64'd16);
        chk("w16_product", 64'(do16), 64'h0000_8000);
        chk("w16_x", 64'(x16), 64'd0);

        // WIDTH=2 unsigned.
        @(negedge clk);
        sm2 = 1'b0; a2 = 2'd3; b2 = 2'd3; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("w2_latency", 64'(cyc), 64'd2);
        chk("w2_product", 64'(do2), 64'h9);
        chk("w2_x", 64'(x2), 64'd0);
        @(negedge clk);
        chk("w2_idle_after", {62'd0, busy2, done2}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Parametrised sequential shift-add multiplier: the accumulator register A, the sign/carry bit X and the multiplier register B are combined with their own control FSM.
- Multiplies a WIDTH-bit multiplicand by a WIDTH-bit multiplier, processing one multiplier bit per clock. Supports unsigned and two's-complement modes.
- Uses a Start/Done handshake and a synchronous Abort.
- Sits between the operand switches/registers and the product display path.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request a multiply; sampled only in IDLE
- Abort  in  1  synchronous cancel; returns to IDLE
- Signed_Mode  in  1  1 = two's-complement, 0 = unsigned; latched at Start
- A_in  in  WIDTH  multiplicand (S)
- B_in  in  WIDTH  multiplier
- Data_Out  out  2*WIDTH  {A, B} register; holds the product after Done
- X  out  1  sign/carry extension bit
- Busy  out  1  high in RUN and DONE
- Done  out  1  one-cycle pulse when the product is valid

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, A=0, B=0, S=0, X=0, count=0, mode=0. Hence Data_Out=0, X=0, Busy=0, Done=0.
- States: IDLE, RUN, DONE (enum in package).
- IDLE:
  - Start=1 at an edge (Abort=0): S<=A_in, B<=B_in, mode<=Signed_Mode, A<=0, X<=0, count<=0, go to RUN.
  - Data_Out holds its previous value in IDLE.
- RUN: every edge performs one iteration. With M = B[0] and last = (count==WIDTH-1):
  - M=0: sum = {X, A} (no add).
  - M=1, signed mode: sum = {A[W-1],A} + {S[W-1],S}. On the last iteration subtract instead: {A[W-1],A} - {S[W-1],S}.
  - M=1, unsigned mode: sum = {1'b0,A} + {1'b0,S}. Never subtract.
  - Arithmetic is WIDTH+1 bits, modulo 2^(WIDTH+1).
  - Register update: {X, A, B} <= {sum[W], sum[W], sum[W-1:0], B[W-1:1]}, with the top bit (X) equal to sum[W]. This is one arithmetic right shift of the (2W+1)-bit {X,A,B}, with X kept as the sign/carry.
  - In unsigned mode X after the shift is forced to 0; the carry enters A[W-1].
  - count <= count+1. When last, go to DONE.
- DONE: lasts exactly one cycle; Done=1, Busy=1. Then IDLE; registers hold.
- Latency: if Start is sampled at edge 0, Done is high for the cycle after edge WIDTH, i.e. WIDTH+1 edges from start to return to IDLE.
- Busy = (state != IDLE). Done is registered: state==DONE.
- Start while RUN or DONE is ignored; operands are not re-latched and there is no queueing.
- Abort=1 at any edge: state<=IDLE, A<=0, X<=0, count<=0. B and S are retained.
  - Abort has priority over Start in IDLE.
  - Done never asserts for an aborted operation.
- Reset asserted mid-RUN clears immediately (asynchronously). No Done is produced.
- Operand inputs may change freely after the Start edge without affecting the result.
- Counter width: $clog2(WIDTH). A count value of WIDTH is never reached.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t
  - MAX_WIDTH = 32
- Sub-module add_sub_ext (WIDTH parameter):
  - Combinational (WIDTH+1)-bit adder/subtractor.
  - Inputs: a, b, sub, sign_ext. Output: sum[W:0].
  - Instanced once. The FSM, counter and shift register stay in shift_add_mult.

Test Plan:
- W=8, unsigned, A_in=0xFF, B_in=0xFF, Start pulse -> Done exactly 8 edges after the Start edge; Data_Out=0xFE01, X=0; Busy high for 9 cycles.
- W=8, signed, A_in=0xFD (-3), B_in=0x07 -> Data_Out=0xFFEB (-21). Then A_in=0x80, B_in=0x7F -> Data_Out=0xC080. Then A_in=0x80, B_in=0x80 -> Data_Out=0x4000.
- W=8, signed, A_in=0xFF, B_in=0xFF -> Data_Out=0x0001. Start re-pulsed during RUN with B_in=0x00 -> ignored, result still 0x0001, single Done pulse.
- Reset asserted asynchronously mid-edge-cycle during iteration 4 -> Data_Out=0, Busy=0, Done=0 before the next Clk edge. A fresh Start of 0x03*0x05 (unsigned) -> 0x000F.
- Abort at iteration 5 -> IDLE next edge, Busy=0, no Done, Data_Out[15:8]=0. Abort and Start together in IDLE -> stays IDLE.
- WIDTH=16, signed, A_in=0x8000, B_in=0xFFFF -> Data_Out=0x00008000, Done after 16 edges. WIDTH=2, unsigned, 3*3 -> 0x9.
